clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel programmable clock divider; successor to the fixed divide-by-4 camera XCLK divider.
//  Each of NUM_CH channels emits a divided clock level (o_clk) plus a 1-cycle enable strobe (o_tick)
//  at its rising edge, with a runtime divisor loaded over a valid/ready port.
//  Divisor changes and disables take effect only at period boundaries, so outputs never glitch.
//  Sits beside the camera/VGA front end; drives XCLK and pixel-rate clock enables.
// PARAMETERS
//  NUM_CH   2   number of independent divider channels (>=1)
//  CNT_W    8   divisor/counter width; max divisor 2**CNT_W-1
//  DEF_DIV  4   divisor loaded into every channel at reset; elaboration error if <2 or >=2**CNT_W
//  CH_W     $clog2(NUM_CH) (min 1)   channel-select width (localparam)
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  rst_n        in   1       synchronous reset, active low
//  i_en         in   NUM_CH  per-channel run enable
//  i_cfg_valid  in   1       divisor write request
//  o_cfg_ready  out  1       write accepted when high with i_cfg_valid
//  i_cfg_ch     in   CH_W    target channel; values >=NUM_CH ignored (accepted, o_cfg_err)
//  i_cfg_div    in   CNT_W   new divisor
//  o_cfg_err    out  1       1-cycle pulse: last accepted write was rejected
//  o_clk        out  NUM_CH  divided clock levels (registered)
//  o_tick       out  NUM_CH  1-cycle pulse coincident with each o_clk rising edge (registered)
//  i_sync       in   1       (CLK_DIV_SYNC_EN only) phase-align pulse
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): cnt=0, running=0, div=DEF_DIV, pending=0 all channels;
//    o_clk=0, o_tick=0, o_cfg_err=0; o_cfg_ready=1 after reset. Reset mid-period aborts immediately.
//  - Per channel: hi=(div+1)>>1. Period = div cycles: o_clk high hi cycles, low div-hi cycles
//    (odd divisors: high phase one cycle longer). Divide-by-4 -> 2 high / 2 low.
//  - Start: idle channel with i_en=1 sampled at edge E -> after E: running=1, cnt=0, o_clk=1, o_tick=1.
//  - Running: each edge cnt<=cnt+1; o_clk<=(cnt+1<hi); o_tick<=0. At cnt==div-1 (boundary):
//    apply pending div if any; if i_en=1 restart (cnt=0, o_clk=1, o_tick=1) else go idle (o_clk=0).
//  - Disable is deferred: dropping i_en mid-period completes the current period; re-raising before
//    the boundary continues seamlessly with no gap.
//  - Config: o_cfg_ready = !pending[i_cfg_ch] (combinational on i_cfg_ch, registered pending).
//    Accept on valid&&ready. i_cfg_div<2 or bad channel -> not stored, o_cfg_err=1 next cycle.
//    Valid write: stored in per-channel pending slot; applied at next boundary, or on the next
//    edge if the channel is idle; pending cleared when applied. One slot per channel; backpressure
//    on a second write to the same channel until applied. Writes to other channels unaffected.
//  - Idle channel: o_clk=0, o_tick=0, cnt held 0.
// CONFIGURATION
//  CLK_DIV_SYNC_EN defined: i_sync port exists. i_sync=1 at edge E -> every channel with i_en=1
//    restarts after E (pending divisors applied, cnt=0, o_clk=1, o_tick=1); idle channels with i_en=1
//    start; channels with i_en=0 go idle immediately. Highest priority after reset.
//  Undefined: no i_sync port, no alignment logic; channels free-run independently.
// TESTING
//  1 Reset, en=1 ch0, DEF_DIV=4 -> o_clk 1100 repeating, o_tick once per 4 cycles, first tick cycle after en.
//  2 Write div=5 ch0 mid-period -> current period completes as 4; next periods 11100, ready low until applied.
//  3 Write div=1 and div=0 -> o_cfg_err pulse each, divisor unchanged, ready stays 1.
//  4 Drop en at cnt=1 of div=6 -> completes 6-cycle period then o_clk=0; re-raise at cnt=3 -> no gap.
//  5 Two channels div 3 and 7 running; rst_n=0 mid-period -> all outputs 0 next edge, div back to 4.
//  6 (SYNC_EN) ch0 div=4, ch1 div=6 out of phase; pulse i_sync -> both o_tick=1 same cycle after.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: divisor configuration port (valid/ready write plus reject pulse) for clk_div_prog.
// Latency: pure wiring; o_cfg_ready is combinational in the divider, o_cfg_err arrives one edge after the write.
// Backpressure: master holds i_cfg_valid/ch/div until o_cfg_ready is seen high at a clock edge.
interface clk_div_prog_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             i_cfg_valid;
   logic             o_cfg_ready;
   logic [CH_W-1:0]  i_cfg_ch;
   logic [CNT_W-1:0] i_cfg_div;
   logic             o_cfg_err;

   // Driver of divisor writes (testbench / control plane).
   modport master (
      output i_cfg_valid,
      output i_cfg_ch,
      output i_cfg_div,
      input  o_cfg_ready,
      input  o_cfg_err
   );

   // The divider itself.
   modport slave (
      input  i_cfg_valid,
      input  i_cfg_ch,
      input  i_cfg_div,
      output o_cfg_ready,
      output o_cfg_err
   );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: NUM_CH programmable clock dividers; divisor and enable changes only land on period boundaries.
// Latency: o_clk/o_tick registered; idle channel starts one edge after i_en=1; new divisor at next boundary (next edge if idle).
// Backpressure: o_cfg_ready low for a channel whose single pending slot is full. Optional i_sync port under CLK_DIV_SYNC_EN.
module clk_div_prog #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] i_en,
`ifdef CLK_DIV_SYNC_EN
   input  logic              i_sync,
`endif
   clk_div_prog_if.slave     cfg,
   output logic [NUM_CH-1:0] o_clk,
   output logic [NUM_CH-1:0] o_tick
);

   localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

   // Reject illegal build configurations at elaboration.
   generate
      if (DEF_DIV < 2 || DEF_DIV >= (2 ** CNT_W)) begin : g_bad_def_div
         $error("clk_div_prog: DEF_DIV must be in [2, 2**CNT_W-1]");
      end
      if (NUM_CH < 1) begin : g_bad_num_ch
         $error("clk_div_prog: NUM_CH must be >= 1");
      end
   endgenerate

   // Per-channel state
   logic [CNT_W-1:0]  r_cnt      [NUM_CH];
   logic [CNT_W-1:0]  r_div      [NUM_CH];
   logic [CNT_W-1:0]  r_pend_div [NUM_CH];
   logic [NUM_CH-1:0] r_run;
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_clk;
   logic [NUM_CH-1:0] r_tick;
   logic              r_err;

   // Combinational helpers
   logic              w_sync;
   logic [CH_W-1:0]   w_ch;
   logic              w_ch_ok;
   logic              w_div_ok;
   logic              w_rdy;
   logic              w_acc;
   logic              w_wr_ok;
   logic [NUM_CH-1:0] w_wr_hit;
   logic [NUM_CH-1:0] w_bound;
   logic [NUM_CH-1:0] w_reload;
   logic [CNT_W-1:0]  w_cnt_nx [NUM_CH];
   logic [CNT_W-1:0]  w_hi     [NUM_CH];

`ifdef CLK_DIV_SYNC_EN
   assign w_sync = i_sync;
`else
   assign w_sync = 1'b0;
`endif

   // Config decode: the ready is per target channel, so a full slot only stalls writes to that channel.
   always_comb begin
      w_ch     = cfg.i_cfg_ch;
      w_ch_ok  = (32'(w_ch) < 32'(NUM_CH));
      w_div_ok = (cfg.i_cfg_div >= TWO);
      w_rdy    = w_ch_ok ? ~r_pend[w_ch] : 1'b1;
      w_acc    = cfg.i_cfg_valid && w_rdy;
      w_wr_ok  = w_acc && w_ch_ok && w_div_ok;
   end

   // Per-channel next count, high-phase length and boundary/reload decisions.
   always_comb begin
      logic [CNT_W:0] v_sum;
      v_sum = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_wr_hit[c] = w_wr_ok && (32'(w_ch) == 32'(c));
         w_cnt_nx[c] = r_cnt[c] + ONE;
         // hi = (div+1)>>1 so odd divisors get the longer high phase
         v_sum       = {1'b0, r_div[c]} + {{CNT_W{1'b0}}, 1'b1};
         w_hi[c]     = v_sum[CNT_W:1];
         w_bound[c]  = r_run[c] && (r_cnt[c] == (r_div[c] - ONE));
         // Idle channels, period ends and sync pulses all re-decide run state from i_en.
         w_reload[c] = w_sync || !r_run[c] || w_bound[c];
      end
   end

   // Channel counters, output levels/strobes and pending-divisor slots.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run  <= '0;
         r_pend <= '0;
         r_clk  <= '0;
         r_tick <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_cnt[c]      <= '0;
            r_div[c]      <= DEF_DIV_V;
            r_pend_div[c] <= DEF_DIV_V;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_reload[c]) begin
               r_cnt[c]  <= '0;
               r_run[c]  <= i_en[c];
               r_clk[c]  <= i_en[c];
               r_tick[c] <= i_en[c];
               if (r_pend[c]) begin
                  r_div[c]  <= r_pend_div[c];
                  r_pend[c] <= 1'b0;
               end
            end else begin
               r_cnt[c]  <= w_cnt_nx[c];
               r_clk[c]  <= (w_cnt_nx[c] < w_hi[c]);
               r_tick[c] <= 1'b0;
            end
            // A write is only accepted into an empty slot, so it never races the apply above.
            if (w_wr_hit[c]) begin
               r_pend[c]     <= 1'b1;
               r_pend_div[c] <= cfg.i_cfg_div;
            end
         end
      end
   end

   // One-cycle reject pulse for an accepted write with a bad divisor or channel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_acc && !(w_ch_ok && w_div_ok);
      end
   end

   assign o_clk           = r_clk;
   assign o_tick          = r_tick;
   assign cfg.o_cfg_ready = w_rdy;
   assign cfg.o_cfg_err   = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of clk_div_prog waveforms, config handshake, deferred disable and reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point (reflect the edge just taken).
// Backpressure: o_cfg_ready observed directly; writes issued only when ready is expected high.
module tb_clk_div_prog;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] o_clk_w;
   logic [NUM_CH-1:0] o_tick_w;
`ifdef CLK_DIV_SYNC_EN
   logic              sync;
`endif

   int checks   = 0;
   int failures = 0;

   clk_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

   clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
`ifdef CLK_DIV_SYNC_EN
      .i_sync (sync),
`endif
      .cfg    (cfg_if),
      .o_clk  (o_clk_w),
      .o_tick (o_tick_w)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      en                 = '0;
      cfg_if.i_cfg_valid = 1'b0;
      cfg_if.i_cfg_ch    = '0;
      cfg_if.i_cfg_div   = '0;
`ifdef CLK_DIV_SYNC_EN
      sync               = 1'b0;
`endif
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      en    = 2'b11;
      step();
      checks++; if (o_clk_w !== 2'b00) begin failures++; $display("FAIL rst_clk got=%b exp=00", o_clk_w); end
      checks++; if (o_tick_w !== 2'b00) begin failures++; $display("FAIL rst_tick got=%b exp=00", o_tick_w); end
      checks++; if (cfg_if.o_cfg_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", cfg_if.o_cfg_err); end
      checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cfg_if.o_cfg_ready); end
      rst_n = 1'b1;
      en    = '0;
   endtask

   task automatic test_div4();
      logic [7:0] exp_clk;
      logic [7:0] exp_tick;
      exp_clk  = 8'b11001100;
      exp_tick = 8'b10001000;
      do_reset();
      en = 2'b01;
      step();
      for (int i = 0; i < 8; i++) begin
         checks++; if (o_clk_w[0] !== exp_clk[7-i]) begin failures++; $display("FAIL div4_clk k=%0d got=%b exp=%b", i, o_clk_w[0], exp_clk[7-i]); end
         checks++; if (o_tick_w[0] !== exp_tick[7-i]) begin failures++; $display("FAIL div4_tick k=%0d got=%b exp=%b", i, o_tick_w[0], exp_tick[7-i]); end
         step();
      end
      checks++; if (o_clk_w[1] !== 1'b0) begin failures++; $display("FAIL div4_ch1_idle got=%b exp=0", o_clk_w[1]); end
   endtask

   task automatic test_div_change();
      logic [11:0] exp_clk;
      logic [11:0] exp_tick;
      logic [11:0] exp_rdy;
      exp_clk  = 12'b001110011100;
      exp_tick = 12'b001000010000;
      exp_rdy  = 12'b001111111111;
      do_reset();
      en = 2'b01;
      step();
      step();
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_ch    = 1'b0;
      cfg_if.i_cfg_div   = 8'd5;
      #1;
      checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL chg_ready_pre got=%b exp=1", cfg_if.o_cfg_ready); end
      step();
      cfg_if.i_cfg_valid = 1'b0;
      checks++; if (cfg_if.o_cfg_err !== 1'b0) begin failures++; $display("FAIL chg_err got=%b exp=0", cfg_if.o_cfg_err); end
      cfg_if.i_cfg_ch = 1'b1;
      #1;
      checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL chg_ready_other got=%b exp=1", cfg_if.o_cfg_ready); end
      cfg_if.i_cfg_ch = 1'b0;
      #1;
      for (int i = 0; i < 12; i++) begin
         checks++; if (o_clk_w[0] !== exp_clk[11-i]) begin failures++; $display("FAIL chg_clk k=%0d got=%b exp=%b", i + 2, o_clk_w[0], exp_clk[11-i]); end
         checks++; if (o_tick_w[0] !== exp_tick[11-i]) begin failures++; $display("FAIL chg_tick k=%0d got=%b exp=%b", i + 2, o_tick_w[0], exp_tick[11-i]); end
         checks++; if (cfg_if.o_cfg_ready !== exp_rdy[11-i]) begin failures++; $display("FAIL chg_ready k=%0d got=%b exp=%b", i + 2, cfg_if.o_cfg_ready, exp_rdy[11-i]); end
         step();
      end
   endtask

   task automatic test_cfg_err();
      logic [3:0] exp_clk;
      logic [3:0] exp_tick;
      exp_clk  = 4'b1100;
      exp_tick = 4'b1000;
      do_reset();
      for (int d = 1; d >= 0; d--) begin
         cfg_if.i_cfg_valid = 1'b1;
         cfg_if.i_cfg_ch    = 1'b0;
         cfg_if.i_cfg_div   = 8'(d);
         #1;
         checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready_pre div=%0d got=%b exp=1", d, cfg_if.o_cfg_ready); end
         step();
         cfg_if.i_cfg_valid = 1'b0;
         checks++; if (cfg_if.o_cfg_err !== 1'b1) begin failures++; $display("FAIL err_pulse div=%0d got=%b exp=1", d, cfg_if.o_cfg_err); end
         checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready div=%0d got=%b exp=1", d, cfg_if.o_cfg_ready); end
         step();
         checks++; if (cfg_if.o_cfg_err !== 1'b0) begin failures++; $display("FAIL err_clear div=%0d got=%b exp=0", d, cfg_if.o_cfg_err); end
      end
      en = 2'b01;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (o_clk_w[0] !== exp_clk[3-i]) begin failures++; $display("FAIL err_div_kept k=%0d got=%b exp=%b", i, o_clk_w[0], exp_clk[3-i]); end
         checks++; if (o_tick_w[0] !== exp_tick[3-i]) begin failures++; $display("FAIL err_tick k=%0d got=%b exp=%b", i, o_tick_w[0], exp_tick[3-i]); end
         step();
      end
   endtask

   task automatic test_disable();
      logic [7:0] exp_clk_a;
      logic [8:0] exp_clk_b;
      logic [8:0] exp_tick_b;
      exp_clk_a  = 8'b11000000;
      exp_clk_b  = 9'b111000111;
      exp_tick_b = 9'b100000100;
      do_reset();
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_ch    = 1'b0;
      cfg_if.i_cfg_div   = 8'd6;
      step();
      cfg_if.i_cfg_valid = 1'b0;
      step();
      en = 2'b01;
      step();
      step();
      en = 2'b00;
      for (int i = 0; i < 8; i++) begin
         checks++; if (o_clk_w[0] !== exp_clk_a[7-i]) begin failures++; $display("FAIL dis_clk k=%0d got=%b exp=%b", i + 1, o_clk_w[0], exp_clk_a[7-i]); end
         checks++; if (o_tick_w[0] !== 1'b0) begin failures++; $display("FAIL dis_tick k=%0d got=%b exp=0", i + 1, o_tick_w[0]); end
         step();
      end
      en = 2'b01;
      step();
      for (int i = 0; i < 9; i++) begin
         checks++; if (o_clk_w[0] !== exp_clk_b[8-i]) begin failures++; $display("FAIL reen_clk k=%0d got=%b exp=%b", i, o_clk_w[0], exp_clk_b[8-i]); end
         checks++; if (o_tick_w[0] !== exp_tick_b[8-i]) begin failures++; $display("FAIL reen_tick k=%0d got=%b exp=%b", i, o_tick_w[0], exp_tick_b[8-i]); end
         if (i == 1) en = 2'b00;
         if (i == 3) en = 2'b01;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_clk  [5];
      logic [1:0] exp_tick [5];
      logic [1:0] exp_clk4 [4];
      logic [1:0] exp_tick4[4];
      exp_clk   = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01};
      exp_tick  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
      exp_clk4  = '{2'b11, 2'b11, 2'b00, 2'b00};
      exp_tick4 = '{2'b11, 2'b00, 2'b00, 2'b00};
      do_reset();
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_ch    = 1'b0;
      cfg_if.i_cfg_div   = 8'd3;
      step();
      cfg_if.i_cfg_ch    = 1'b1;
      cfg_if.i_cfg_div   = 8'd7;
      step();
      cfg_if.i_cfg_valid = 1'b0;
      step();
      en = 2'b11;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++; if (o_clk_w !== exp_clk[i]) begin failures++; $display("FAIL two_clk k=%0d got=%b exp=%b", i, o_clk_w, exp_clk[i]); end
         checks++; if (o_tick_w !== exp_tick[i]) begin failures++; $display("FAIL two_tick k=%0d got=%b exp=%b", i, o_tick_w, exp_tick[i]); end
         if (i < 4) step();
      end
      rst_n = 1'b0;
      step();
      checks++; if (o_clk_w !== 2'b00) begin failures++; $display("FAIL midrst_clk got=%b exp=00", o_clk_w); end
      checks++; if (o_tick_w !== 2'b00) begin failures++; $display("FAIL midrst_tick got=%b exp=00", o_tick_w); end
      checks++; if (cfg_if.o_cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", cfg_if.o_cfg_ready); end
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (o_clk_w !== exp_clk4[i]) begin failures++; $display("FAIL postrst_clk k=%0d got=%b exp=%b", i, o_clk_w, exp_clk4[i]); end
         checks++; if (o_tick_w !== exp_tick4[i]) begin failures++; $display("FAIL postrst_tick k=%0d got=%b exp=%b", i, o_tick_w, exp_tick4[i]); end
         step();
      end
   endtask

`ifdef CLK_DIV_SYNC_EN
   task automatic test_sync();
      do_reset();
      cfg_if.i_cfg_valid = 1'b1;
      cfg_if.i_cfg_ch    = 1'b1;
      cfg_if.i_cfg_div   = 8'd6;
      step();
      cfg_if.i_cfg_valid = 1'b0;
      step();
      en = 2'b01;
      step();
      step();
      step();
      en = 2'b11;
      step();
      step();
      step();
      checks++; if (o_tick_w !== 2'b00) begin failures++; $display("FAIL sync_pre_tick got=%b exp=00", o_tick_w); end
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++; if (o_tick_w !== 2'b11) begin failures++; $display("FAIL sync_tick got=%b exp=11", o_tick_w); end
      checks++; if (o_clk_w !== 2'b11) begin failures++; $display("FAIL sync_clk got=%b exp=11", o_clk_w); end
      step();
      checks++; if (o_tick_w !== 2'b00) begin failures++; $display("FAIL sync_tick1 got=%b exp=00", o_tick_w); end
      step();
      checks++; if (o_clk_w !== 2'b10) begin failures++; $display("FAIL sync_clk2 got=%b exp=10", o_clk_w); end
      en   = 2'b01;
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++; if (o_clk_w !== 2'b01) begin failures++; $display("FAIL sync_idle_clk got=%b exp=01", o_clk_w); end
      checks++; if (o_tick_w !== 2'b01) begin failures++; $display("FAIL sync_idle_tick got=%b exp=01", o_tick_w); end
   endtask
`endif

   initial begin
      test_reset();
      test_div4();
      test_div_change();
      test_cfg_err();
      test_disable();
      test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
      test_sync();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
